// File: rtl/seq_decoder_pkg.sv
// +--------------------------------------------------------------------------+
// | seq_decoder_pkg : shared types, mode encodings and one-hot helper         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package seq_decoder_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Callers narrow the result to their own output width with a size cast.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    onehot = MAX_OUT_W'(1) << sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_decoder_dwell_cnt.sv
// +--------------------------------------------------------------------------+
// | seq_decoder_dwell_cnt : loadable down-counter with zero flag              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_decoder_dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  // clr beats load beats dec; the counter saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/seq_decoder.sv
// +--------------------------------------------------------------------------+
// | seq_decoder : registered SEL_W:2**SEL_W decoder with DECODE / SCAN modes  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<SEL_W)-1:0] y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam int OUT_W = 1 << SEL_W;

  state_t             state, state_nxt;
  logic [OUT_W-1:0]   y_nxt;
  logic               y_valid_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic               wrap_nxt;
  logic               accept;
  logic               cnt_clr, cnt_load, cnt_dec, cnt_zero;

  assign sel_ready = en & (mode == MODE_DECODE) & ~rst;
  assign accept    = sel_valid & sel_ready;

  seq_decoder_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (dwell),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OFF;
      y       <= '0;
      y_valid <= 1'b0;
      idx     <= '0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      idx     <= idx_nxt;
      wrap    <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    y_nxt       = y;
    y_valid_nxt = y_valid;
    idx_nxt     = idx;
    wrap_nxt    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    if (!en) begin
      state_nxt   = ST_OFF;
      y_nxt       = '0;
      y_valid_nxt = 1'b0;
      cnt_clr     = 1'b0 | 1'b1;
    end else if (mode == MODE_DECODE) begin
      // Leaving SCAN freezes y/idx until a select is accepted.
      state_nxt = ST_HOLD;
      if (accept) begin
        y_nxt       = OUT_W'(onehot(MAX_SEL_W'(sel)));
        idx_nxt     = sel;
        y_valid_nxt = 1'b1;
      end
    end else if (mode == MODE_SCAN) begin
      state_nxt = ST_SCAN;
      if (state != ST_SCAN) begin
        y_nxt       = OUT_W'(1);
        idx_nxt     = '0;
        y_valid_nxt = 1'b1;
        cnt_load    = 1'b1;
      end else if (cnt_zero) begin
        // dwell is sampled only here, so mid-dwell changes wait for the next step.
        y_nxt       = {y[OUT_W-2:0], y[OUT_W-1]};
        idx_nxt     = idx + SEL_W'(1);
        y_valid_nxt = 1'b1;
        wrap_nxt    = (idx == '1);
        cnt_load    = 1'b1;
      end else begin
        cnt_dec = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_seq_decoder : scoreboard bench for seq_decoder (SEL_W=3 and SEL_W=4)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SEL_W=3
  logic        rst_a, en_a, mode_a, sv_a, rdy_a, yv_a, wrap_a;
  logic [2:0]  sel_a, idx_a;
  logic [3:0]  dwell_a;
  logic [7:0]  y_a;

  // Instance B: SEL_W=4
  logic        rst_b, en_b, mode_b, sv_b, rdy_b, yv_b, wrap_b;
  logic [3:0]  sel_b, idx_b;
  logic [3:0]  dwell_b;
  logic [15:0] y_b;

  seq_decoder #(.SEL_W(3), .DWELL_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel_valid(sv_a), .sel(sel_a),
    .sel_ready(rdy_a), .dwell(dwell_a), .y(y_a), .y_valid(yv_a), .idx(idx_a), .wrap(wrap_a)
  );

  seq_decoder #(.SEL_W(4), .DWELL_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel_valid(sv_b), .sel(sel_b),
    .sel_ready(rdy_b), .dwell(dwell_b), .y(y_b), .y_valid(yv_b), .idx(idx_b), .wrap(wrap_b)
  );

  typedef struct {
    logic [15:0] y;
    logic        yv;
    logic [3:0]  idx;
    logic        wrap;
    logic        rdy;
    string       tag;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h  {y,y_valid,idx,wrap,sel_ready}", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check(e.tag, 32'({y_a, yv_a, idx_a, wrap_a, rdy_a}),
            32'({e.y[7:0], e.yv, e.idx[2:0], e.wrap, e.rdy}));
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check(e.tag, 32'({y_b, yv_b, idx_b, wrap_b, rdy_b}),
            32'({e.y, e.yv, e.idx, e.wrap, e.rdy}));
    end
  end

  // Drives inputs for the coming edge; the expectation is for the outputs
  // visible now, i.e. the result of the previous edge.
  task automatic step_a(input logic e, input logic m, input logic v, input logic [2:0] s,
                        input logic [3:0] d, input logic [7:0] ey, input logic eyv,
                        input logic [2:0] ei, input logic ew, input string tag);
    exp_t x;
    en_a = e; mode_a = m; sv_a = v; sel_a = s; dwell_a = d;
    x.y = 16'(ey); x.yv = eyv; x.idx = 4'(ei); x.wrap = ew;
    x.rdy = e & ~m & ~rst_a; x.tag = tag;
    q_a.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic e, input logic m, input logic [3:0] d,
                        input logic [15:0] ey, input logic eyv, input logic [3:0] ei,
                        input logic ew, input string tag);
    exp_t x;
    en_b = e; mode_b = m; dwell_b = d;
    x.y = ey; x.yv = eyv; x.idx = ei; x.wrap = ew;
    x.rdy = e & ~m & ~rst_b; x.tag = tag;
    q_b.push_back(x);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; sv_a = 1'b0; sel_a = '0; dwell_a = '0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; sv_b = 1'b1; sel_b = 4'd7; dwell_b = '0;
    @(posedge clk); #1;

    // Reset held two cycles with en high: sel_ready must stay low.
    step_a(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, "reset");
    step_a(1, 0, 1, 5, 0, 8'h00, 0, 0, 0, "reset_rdy");
    rst_a = 1'b0;

    step_a(1, 0, 1, 5, 0, 8'h00, 0, 0, 0, "hs5");
    for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, 0, 8'h20, 1, 5, 0, "hold5");

    // Exhaustive decode sweep, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step_a(1, 0, 1, 3'(i), 0, 8'h20, 1, 5, 0, "sweep");
      else        step_a(1, 0, 1, 3'(i), 0, 8'(1 << (i - 1)), 1, 3'(i - 1), 0, "sweep");
    end
    step_a(1, 0, 0, 0, 0, 8'h80, 1, 7, 0, "sweep_end");

    // Scan with dwell=2: each position held 3 cycles, no wrap on entry.
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 3; c++)
        step_a(1, 1, 0, 0, 2, (p == 0 && c == 0) ? 8'h80 : 8'(1 << (p - ((c == 0) ? 1 : 0))),
               1, (p == 0 && c == 0) ? 3'd7 : 3'(p - ((c == 0) ? 1 : 0)), 0, "scan_d2");
    // Last position 7 occupies one more cycle after the table above.
    step_a(1, 1, 0, 0, 2, 8'h80, 1, 7, 0, "scan_d2_p7");
    step_a(1, 1, 0, 0, 2, 8'h01, 1, 0, 1, "wrap_d2");
    step_a(1, 1, 0, 0, 0, 8'h01, 1, 0, 0, "wrap_d2_c1");
    step_a(1, 1, 0, 0, 0, 8'h01, 1, 0, 0, "wrap_d2_c2");

    // dwell=0: step every cycle, wrap every 8.
    for (int p = 1; p < 8; p++) step_a(1, 1, 0, 0, 0, 8'(1 << p), 1, 3'(p), 0, "scan_d0");
    step_a(1, 1, 0, 0, 0, 8'h01, 1, 0, 1, "wrap_d0");
    for (int p = 1; p < 8; p++) step_a(1, 1, 0, 0, 0, 8'(1 << p), 1, 3'(p), 0, "scan_d0b");
    step_a(1, 1, 0, 0, 3, 8'h01, 1, 0, 1, "wrap_d0b");

    // dwell 3 -> 0 at second cycle of position 2.
    for (int c = 0; c < 4; c++) step_a(1, 1, 0, 0, 3, 8'h02, 1, 1, 0, "mid_p1");
    step_a(1, 1, 0, 0, 3, 8'h04, 1, 2, 0, "mid_p2");
    for (int c = 1; c < 4; c++) step_a(1, 1, 0, 0, 0, 8'h04, 1, 2, 0, "mid_p2");
    for (int p = 3; p < 6; p++) step_a(1, 1, 0, 0, 0, 8'(1 << p), 1, 3'(p), 0, "mid_fast");

    // Mode / enable switching.
    step_a(1, 0, 0, 0, 0, 8'h40, 1, 6, 0, "to_decode");
    step_a(1, 0, 0, 0, 0, 8'h40, 1, 6, 0, "frozen");
    step_a(1, 0, 1, 1, 0, 8'h40, 1, 6, 0, "sel1_hs");
    step_a(1, 1, 0, 0, 0, 8'h02, 1, 1, 0, "sel1_out");
    step_a(1, 1, 0, 0, 0, 8'h01, 1, 0, 0, "rescan");
    step_a(1, 1, 0, 0, 0, 8'h02, 1, 1, 0, "rescan_p1");
    step_a(0, 1, 0, 0, 0, 8'h04, 1, 2, 0, "en_drop");
    step_a(0, 0, 1, 3, 0, 8'h00, 0, 2, 0, "off_hs");
    step_a(0, 0, 0, 0, 0, 8'h00, 0, 2, 0, "off_idx");

    // Instance B: async reset mid-scan, dwell=1.
    rst_b = 1'b0;
    step_b(1, 1, 1, 16'h0000, 0, 0, 0, "b_off");
    for (int p = 0; p < 9; p++)
      for (int c = 0; c < 2; c++)
        step_b(1, 1, 1, 16'(1 << p), 1, 4'(p), 0, "b_scan");
    check("b_idx9", 32'({y_b, yv_b, idx_b}), 32'({16'h0200, 1'b1, 4'd9}));
    #2 rst_b = 1'b1;
    #1 check("b_async_rst", 32'({y_b, yv_b, idx_b, wrap_b, rdy_b}), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    step_b(1, 1, 1, 16'h0000, 0, 0, 0, "b_restart_off");
    step_b(1, 1, 1, 16'h0001, 1, 0, 0, "b_restart");
    step_b(1, 1, 1, 16'h0001, 1, 0, 0, "b_restart_c1");
    step_b(1, 1, 1, 16'h0002, 1, 1, 0, "b_restart_p1");

    @(negedge clk); #1;
    check("queue_drain", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
